// File: rtl/wb_select_if.sv
// Writeback-stage bus: request/handshake from the pipeline, mult/div result strobe,
// and the registered register-file write port plus HI/LO and status observation.
interface wb_select_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        wb_sel;
    logic              reg_write;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] link_addr;
    logic              hi_we;
    logic              lo_we;
    logic              md_busy;
    logic              md_valid;
    logic [DATA_W-1:0] md_hi;
    logic [DATA_W-1:0] md_lo;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              sel_err;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output in_valid, wb_sel, reg_write, rd_addr, alu_result, mem_data, link_addr,
               hi_we, lo_we, md_busy, md_valid, md_hi, md_lo,
        input  in_ready, rf_we, rf_waddr, rf_wdata, hi_q, lo_q, sel_err, stall_cnt
    );

    modport slave (
        input  in_valid, wb_sel, reg_write, rd_addr, alu_result, mem_data, link_addr,
               hi_we, lo_we, md_busy, md_valid, md_hi, md_lo,
        output in_ready, rf_we, rf_waddr, rf_wdata, hi_q, lo_q, sel_err, stall_cnt
    );
endinterface

// File: rtl/wb_select_stage.sv
// Registered MIPS writeback select stage with HI/LO registers and mult/div interlock.
// Define HILO_FWD_EN to make HI/LO reads return a same-cycle HI/LO update.
module wb_select_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input logic        clk,
    input logic        rst,
    wb_select_if.slave bus
);
    typedef enum logic {
        RUN     = 1'b0,
        WAIT_MD = 1'b1
    } state_t;

    localparam logic [2:0] SEL_ALU  = 3'b000;
    localparam logic [2:0] SEL_MEM  = 3'b001;
    localparam logic [2:0] SEL_HI   = 3'b010;
    localparam logic [2:0] SEL_LO   = 3'b011;
    localparam logic [2:0] SEL_LINK = 3'b100;

    state_t            state, state_nxt;
    logic              hilo_rd, sel_legal, ready, accept, stall_inc;
    logic [DATA_W-1:0] hi_q, lo_q, hi_nxt, lo_nxt, hi_src, lo_src, wdata_mux;
    logic              rf_we_q, sel_err_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;
    logic [CNT_W-1:0]  stall_q;

    assign hilo_rd   = (bus.wb_sel == SEL_HI) || (bus.wb_sel == SEL_LO);
    assign sel_legal = (bus.wb_sel <= SEL_LINK);
    assign accept    = bus.in_valid && ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (bus.in_valid && !ready) state_nxt = WAIT_MD;
            WAIT_MD: if (!bus.in_valid || ready) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        ready     = 1'b1;
        stall_inc = 1'b0;
        case (state)
            RUN: begin
                ready     = !(bus.in_valid && hilo_rd && bus.md_busy);
                stall_inc = bus.in_valid && !ready;
            end
            WAIT_MD: begin
                ready     = !bus.md_busy;
                stall_inc = bus.md_busy;
            end
            default: ;
        endcase
    end

    // A mult/div result always wins over a same-cycle mthi/mtlo.
    always_comb begin
        hi_nxt = hi_q;
        lo_nxt = lo_q;
        if (bus.md_valid) begin
            hi_nxt = bus.md_hi;
            lo_nxt = bus.md_lo;
        end else if (accept && sel_legal) begin
            if (bus.hi_we) hi_nxt = bus.alu_result;
            if (bus.lo_we) lo_nxt = bus.alu_result;
        end
    end

`ifdef HILO_FWD_EN
    assign hi_src = hi_nxt;
    assign lo_src = lo_nxt;
`else
    assign hi_src = hi_q;
    assign lo_src = lo_q;
`endif

    always_comb begin
        wdata_mux = '0;
        case (bus.wb_sel)
            SEL_ALU:  wdata_mux = bus.alu_result;
            SEL_MEM:  wdata_mux = bus.mem_data;
            SEL_HI:   wdata_mux = hi_src;
            SEL_LO:   wdata_mux = lo_src;
            SEL_LINK: wdata_mux = bus.link_addr;
            default:  wdata_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q       <= '0;
            lo_q       <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            sel_err_q  <= 1'b0;
            stall_q    <= '0;
        end else begin
            hi_q    <= hi_nxt;
            lo_q    <= lo_nxt;
            rf_we_q <= accept && bus.reg_write && sel_legal && (bus.rd_addr != '0);
            if (accept) begin
                rf_waddr_q <= bus.rd_addr;
                rf_wdata_q <= wdata_mux;
            end
            if (accept && !sel_legal) sel_err_q <= 1'b1;
            if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign bus.in_ready  = ready;
    assign bus.rf_we     = rf_we_q;
    assign bus.rf_waddr  = rf_waddr_q;
    assign bus.rf_wdata  = rf_wdata_q;
    assign bus.hi_q      = hi_q;
    assign bus.lo_q      = lo_q;
    assign bus.sel_err   = sel_err_q;
    assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench for wb_select_stage: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the writeback rules.
module tb_wb_select_stage;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_select_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();
    wb_select_stage #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic idle();
        bus.in_valid = 0; bus.wb_sel = 0; bus.reg_write = 0; bus.rd_addr = 0;
        bus.alu_result = 0; bus.mem_data = 0; bus.link_addr = 0;
        bus.hi_we = 0; bus.lo_we = 0; bus.md_busy = 0; bus.md_valid = 0;
        bus.md_hi = 0; bus.md_lo = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1; idle(); tick(); tick(); rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL reset_rf_we got %0h want 0", bus.rf_we); end
        n_cmp++; if (bus.rf_waddr !== '0) begin n_err++; $display("FAIL reset_rf_waddr got %0h want 0", bus.rf_waddr); end
        n_cmp++; if (bus.rf_wdata !== '0) begin n_err++; $display("FAIL reset_rf_wdata got %0h want 0", bus.rf_wdata); end
        n_cmp++; if ({bus.hi_q, bus.lo_q} !== '0) begin n_err++; $display("FAIL reset_hilo got %0h/%0h want 0/0", bus.hi_q, bus.lo_q); end
        n_cmp++; if (bus.sel_err !== 1'b0) begin n_err++; $display("FAIL reset_sel_err got %0h want 0", bus.sel_err); end
        n_cmp++; if (bus.stall_cnt !== '0) begin n_err++; $display("FAIL reset_stall_cnt got %0h want 0", bus.stall_cnt); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0h want 1", bus.in_ready); end
    endtask

    task automatic test_alu_write();
        bus.in_valid = 1; bus.wb_sel = 3'b000; bus.reg_write = 1; bus.rd_addr = 5; bus.alu_result = 32'h1234;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL alu_in_ready got %0h want 1", bus.in_ready); end
        tick(); idle();
        n_cmp++; if (bus.rf_we !== 1'b1) begin n_err++; $display("FAIL alu_rf_we got %0h want 1", bus.rf_we); end
        n_cmp++; if (bus.rf_waddr !== 5'd5) begin n_err++; $display("FAIL alu_rf_waddr got %0d want 5", bus.rf_waddr); end
        n_cmp++; if (bus.rf_wdata !== 32'h0000_1234) begin n_err++; $display("FAIL alu_rf_wdata got %h want 00001234", bus.rf_wdata); end
        tick();
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL idle_rf_we got %0h want 0", bus.rf_we); end
    endtask

    task automatic test_zero_reg();
        bus.in_valid = 1; bus.wb_sel = 3'b001; bus.reg_write = 1; bus.rd_addr = 0; bus.mem_data = 32'hDEAD_BEEF;
        tick(); idle();
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL r0_rf_we got %0h want 0", bus.rf_we); end
        n_cmp++; if (bus.rf_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL r0_rf_wdata got %h want deadbeef", bus.rf_wdata); end
    endtask

    task automatic test_md_stall();
        logic [DW-1:0] exp_wdata;
        do_reset();
        bus.in_valid = 1; bus.wb_sel = 3'b011; bus.reg_write = 1; bus.rd_addr = 8; bus.md_busy = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d] got %0h want 0", i, bus.in_ready); end
            tick();
        end
        n_cmp++; if (bus.stall_cnt !== 16'd4) begin n_err++; $display("FAIL stall_cnt got %0d want 4", bus.stall_cnt); end
        bus.md_busy = 0; bus.md_valid = 1; bus.md_lo = 32'hA5; bus.md_hi = 32'h5A;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready got %0h want 1", bus.in_ready); end
        tick(); idle();
`ifdef HILO_FWD_EN
        exp_wdata = 32'hA5;
`else
        exp_wdata = 32'h0;
`endif
        n_cmp++; if (bus.rf_we !== 1'b1) begin n_err++; $display("FAIL mflo_rf_we got %0h want 1", bus.rf_we); end
        n_cmp++; if (bus.rf_wdata !== exp_wdata) begin n_err++; $display("FAIL mflo_rf_wdata got %h want %h", bus.rf_wdata, exp_wdata); end
        n_cmp++; if (bus.lo_q !== 32'hA5 || bus.hi_q !== 32'h5A) begin n_err++; $display("FAIL md_result got %h/%h want 5a/a5", bus.hi_q, bus.lo_q); end
        n_cmp++; if (bus.stall_cnt !== 16'd4) begin n_err++; $display("FAIL stall_cnt_hold got %0d want 4", bus.stall_cnt); end
    endtask

    task automatic test_md_priority();
        bus.in_valid = 1; bus.hi_we = 1; bus.alu_result = 32'h77;
        bus.md_valid = 1; bus.md_hi = 32'h99; bus.md_lo = 32'h11;
        tick(); idle();
        n_cmp++; if (bus.hi_q !== 32'h99) begin n_err++; $display("FAIL prio_hi got %h want 99", bus.hi_q); end
        n_cmp++; if (bus.lo_q !== 32'h11) begin n_err++; $display("FAIL prio_lo got %h want 11", bus.lo_q); end
        bus.in_valid = 1; bus.lo_we = 1; bus.alu_result = 32'h33;
        tick(); idle();
        n_cmp++; if (bus.lo_q !== 32'h33 || bus.hi_q !== 32'h99) begin n_err++; $display("FAIL mtlo got %h/%h want 99/33", bus.hi_q, bus.lo_q); end
    endtask

    task automatic test_illegal_sel();
        bus.in_valid = 1; bus.wb_sel = 3'b110; bus.reg_write = 1; bus.rd_addr = 3;
        tick(); idle();
        n_cmp++; if (bus.sel_err !== 1'b1) begin n_err++; $display("FAIL illegal_sel_err got %0h want 1", bus.sel_err); end
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_err++; $display("FAIL illegal_rf_we got %0h want 0", bus.rf_we); end
        bus.in_valid = 1; bus.wb_sel = 3'b000; bus.reg_write = 1; bus.rd_addr = 4; bus.alu_result = 32'hCAFE;
        tick(); idle();
        n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_wdata !== 32'hCAFE) begin n_err++; $display("FAIL after_illegal got we=%0h d=%h want 1/cafe", bus.rf_we, bus.rf_wdata); end
        tick();
        n_cmp++; if (bus.sel_err !== 1'b1) begin n_err++; $display("FAIL sticky_sel_err got %0h want 1", bus.sel_err); end
    endtask

    task automatic test_jal();
        bus.in_valid = 1; bus.wb_sel = 3'b100; bus.reg_write = 1; bus.rd_addr = 31; bus.link_addr = 32'h0040_0008;
        tick(); idle();
        n_cmp++; if (bus.rf_waddr !== 5'd31) begin n_err++; $display("FAIL jal_waddr got %0d want 31", bus.rf_waddr); end
        n_cmp++; if (bus.rf_wdata !== 32'h0040_0008) begin n_err++; $display("FAIL jal_wdata got %h want 00400008", bus.rf_wdata); end
    endtask

    task automatic test_reset_mid_stall();
        bus.in_valid = 1; bus.wb_sel = 3'b010; bus.reg_write = 1; bus.rd_addr = 9; bus.md_busy = 1;
        tick(); tick();
        n_cmp++; if (bus.stall_cnt === '0) begin n_err++; $display("FAIL pre_rst_stall got %0d want nonzero", bus.stall_cnt); end
        rst = 1; tick(); rst = 0; idle(); #1;
        n_cmp++; if ({bus.rf_we, bus.rf_waddr, bus.rf_wdata} !== '0) begin n_err++; $display("FAIL rst_stall_rf got %0h/%0h/%h want 0", bus.rf_we, bus.rf_waddr, bus.rf_wdata); end
        n_cmp++; if ({bus.hi_q, bus.lo_q} !== '0) begin n_err++; $display("FAIL rst_stall_hilo got %h/%h want 0", bus.hi_q, bus.lo_q); end
        n_cmp++; if (bus.sel_err !== 1'b0 || bus.stall_cnt !== '0) begin n_err++; $display("FAIL rst_stall_status got %0h/%0d want 0/0", bus.sel_err, bus.stall_cnt); end
        tick();
        n_cmp++; if (bus.rf_we !== 1'b0 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_stall_drop got we=%0h rdy=%0h want 0/1", bus.rf_we, bus.in_ready); end
    endtask

    task automatic test_random();
        logic [DW-1:0] m_hi = '0, m_lo = '0, m_wdata = '0, nh, nl, rh, rl;
        logic [AW-1:0] m_waddr = '0;
        logic          m_we = 0, m_err = 0, pend = 0, v, rdy, acc, legal, hilo;
        int unsigned   m_stall = 0;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            if (!pend) begin
                int unsigned r = $urandom_range(0, 15);
                v = ($urandom_range(0, 3) != 0);
                bus.wb_sel = (r < 14) ? 3'(r % 5) : 3'(5 + r % 3);
                bus.reg_write = $urandom_range(0, 1);
                bus.rd_addr = AW'($urandom_range(0, 7));
                bus.alu_result = $urandom; bus.mem_data = $urandom; bus.link_addr = $urandom;
                bus.hi_we = ($urandom_range(0, 5) == 0); bus.lo_we = ($urandom_range(0, 5) == 0);
            end else v = 1;
            bus.in_valid = v;
            bus.md_busy = $urandom_range(0, 1);
            bus.md_valid = ($urandom_range(0, 4) == 0);
            bus.md_hi = $urandom; bus.md_lo = $urandom;
            #1;
            legal = (bus.wb_sel <= 3'd4);
            hilo = (bus.wb_sel == 3'd2) || (bus.wb_sel == 3'd3);
            rdy = !(v && hilo && bus.md_busy);
            acc = v && rdy;
            n_cmp++; if (bus.in_ready !== rdy) begin n_err++; $display("FAIL rnd_in_ready c=%0d got %0h want %0h", c, bus.in_ready, rdy); end
            if (v && !rdy && m_stall < 65535) m_stall++;
            nh = bus.md_valid ? bus.md_hi : (acc && legal && bus.hi_we) ? bus.alu_result : m_hi;
            nl = bus.md_valid ? bus.md_lo : (acc && legal && bus.lo_we) ? bus.alu_result : m_lo;
`ifdef HILO_FWD_EN
            rh = nh; rl = nl;
`else
            rh = m_hi; rl = m_lo;
`endif
            m_we = acc && bus.reg_write && legal && (bus.rd_addr != 0);
            if (acc) begin
                m_waddr = bus.rd_addr;
                case (bus.wb_sel)
                    3'd0: m_wdata = bus.alu_result;
                    3'd1: m_wdata = bus.mem_data;
                    3'd2: m_wdata = rh;
                    3'd3: m_wdata = rl;
                    3'd4: m_wdata = bus.link_addr;
                    default: m_wdata = '0;
                endcase
            end
            if (acc && !legal) m_err = 1;
            m_hi = nh; m_lo = nl;
            pend = v && !rdy;
            tick();
            n_cmp++; if (bus.rf_we !== m_we || bus.rf_waddr !== m_waddr) begin n_err++; $display("FAIL rnd_we_addr c=%0d got %0h/%0d want %0h/%0d", c, bus.rf_we, bus.rf_waddr, m_we, m_waddr); end
            n_cmp++; if (bus.rf_wdata !== m_wdata) begin n_err++; $display("FAIL rnd_wdata c=%0d got %h want %h", c, bus.rf_wdata, m_wdata); end
            n_cmp++; if (bus.hi_q !== m_hi || bus.lo_q !== m_lo) begin n_err++; $display("FAIL rnd_hilo c=%0d got %h/%h want %h/%h", c, bus.hi_q, bus.lo_q, m_hi, m_lo); end
            n_cmp++; if (bus.sel_err !== m_err || bus.stall_cnt !== CW'(m_stall)) begin n_err++; $display("FAIL rnd_status c=%0d got %0h/%0d want %0h/%0d", c, bus.sel_err, bus.stall_cnt, m_err, m_stall); end
        end
        idle();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_alu_write();
        test_zero_reg();
        test_md_stall();
        test_md_priority();
        test_illegal_sel();
        test_jal();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
Parametrised registered writeback stage for the MIPS datapath. It selects the register-file write value from the ALU, memory, HI, LO or link (PC+4) sources. It owns the HI/LO registers and interlocks HI/LO reads against a busy multi-cycle mult/div unit through a valid/ready handshake. The output is registered and drives the register-file write port directly.

Parameters:
DATA_W, 32, datapath and HI/LO width
ADDR_W, 5, register address width
CNT_W, 16, width of the saturating stall counter

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  writeback request present
in_ready  output  1  stage accepts request this cycle
wb_sel  input  3  source select: 000 ALU, 001 MEM, 010 HI, 011 LO, 100 LINK; 101-111 illegal
reg_write  input  1  request writes the register file
rd_addr  input  ADDR_W  destination register
alu_result  input  DATA_W  ALU result; also the data for mthi/mtlo
mem_data  input  DATA_W  load data
link_addr  input  DATA_W  PC+4 for jal/jalr
hi_we  input  1  mthi: HI <= alu_result on accept
lo_we  input  1  mtlo: LO <= alu_result on accept
md_busy  input  1  mult/div in progress
md_valid  input  1  mult/div result strobe (one cycle)
md_hi  input  DATA_W  mult/div HI result
md_lo  input  DATA_W  mult/div LO result
rf_we  output  1  register-file write enable (registered)
rf_waddr  output  ADDR_W  register-file write address (registered)
rf_wdata  output  DATA_W  register-file write data (registered)
hi_q  output  DATA_W  current HI
lo_q  output  DATA_W  current LO
sel_err  output  1  sticky flag: illegal wb_sel accepted
stall_cnt  output  CNT_W  saturating count of cycles stalled on HI/LO

Behaviour:
- Reset (rst=1 at an edge): rf_we=0, rf_waddr=0, rf_wdata=0, hi_q=0, lo_q=0, sel_err=0, stall_cnt=0, FSM=RUN. Reset mid-stall drops the pending request and returns to RUN.
- Accept means in_valid && in_ready. The stage has 1-cycle latency: an accept at edge N drives rf_* valid after edge N.
- rf_we after an accept = reg_write && wb_sel legal && rd_addr!=0. rf_we=0 in any cycle following no accept. rf_waddr and rf_wdata update on every accept, even when rf_we=0.
- A HI/LO read is wb_sel = 010 or 011.
- FSM RUN:
  - in_ready = !(in_valid && HI/LO read && md_busy).
  - If the request is blocked, go to WAIT_MD and increment stall_cnt.
- FSM WAIT_MD:
  - in_ready = !md_busy; stall_cnt increments each cycle md_busy=1.
  - On accept, return to RUN.
  - If in_valid drops while in WAIT_MD, return to RUN with no write.
- stall_cnt saturates at 2^CNT_W-1 and never wraps.
- HI/LO update priority per edge:
  - md_valid=1: HI<=md_hi, LO<=md_lo. A same-cycle mthi/mtlo is discarded.
  - Otherwise, an accepted hi_we loads HI <= alu_result and an accepted lo_we loads LO <= alu_result. Both may assert together.
- Non-HI/LO selects never stall, regardless of md_busy.
- An illegal wb_sel on accept sets sel_err (cleared only by rst) and forces rf_we=0. No other state is affected.
- rf_wdata = mux of source values at the accept cycle. HI/LO sources use the rules in Optional Feature.

Optional Feature:
Macro HILO_FWD_EN controls how a HI/LO read resolves against a same-cycle HI/LO update.
- Defined: a HI/LO read accepted in the same cycle as an md_valid or accepted mthi/mtlo returns the value being written, using the same priority as above.
- Undefined: the read returns the pre-edge hi_q/lo_q (old value).
- No other behaviour changes.

Test Plan:
- Reset then accept wb_sel=000, reg_write=1, rd_addr=5, alu_result=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x00001234.
- Accept rd_addr=0, reg_write=1, wb_sel=001, mem_data=0xDEADBEEF -> rf_we=0, rf_wdata=0xDEADBEEF.
- md_busy=1 for 4 cycles with a wb_sel=011 request, then md_valid with md_lo=0xA5, md_busy=0 -> in_ready=0 for 4 cycles, stall_cnt=4, rf_wdata=0xA5 (HILO_FWD_EN) or 0x0 (old LO, without).
- mthi with alu_result=0x77 in the same cycle as md_valid, md_hi=0x99 -> hi_q=0x99.
- Accept wb_sel=110 -> sel_err=1, rf_we=0. A following legal write succeeds and sel_err stays 1 until rst.
- jal: wb_sel=100, rd_addr=31, link_addr=0x00400008 -> rf_waddr=31, rf_wdata=0x00400008. Assert rst during a WAIT_MD stall -> all outputs return to their reset values.
